// File: rtl/muldiv_if.sv
// Operand/result bundle between the datapath (master) and the multiply/divide unit (slave).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers: shift-add multiply and restoring
// divide on magnitudes, one bit per clock, with sign correction applied in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // Operand conditioning at issue: op[1]=divide, op[0]=unsigned
    logic                 is_div_in, signed_in, dz_in;
    logic [WIDTH-1:0]     mag_a, mag_b;
    assign is_div_in = bus.op[1];
    assign signed_in = ~bus.op[0];
    assign dz_in     = is_div_in && (bus.b == '0);
    assign mag_a     = (signed_in && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign mag_b     = (signed_in && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    // Multiply step: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   acc_mul_next;
    assign mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign acc_mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   acc_div_next;
    assign div_shift    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff     = div_shift - {1'b0, opnd_q};
    assign acc_div_next = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                          : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    // Sign fix-up; remainder follows the dividend's sign
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    assign prod_fix = (op_q == 2'b00 && (sign_a_q ^ sign_b_q)) ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = (op_q == 2'b10 && (sign_a_q ^ sign_b_q)) ? (~acc_q[WIDTH-1:0] + 1'b1)
                                                               : acc_q[WIDTH-1:0];
    assign rem_fix  = (op_q == 2'b10 && sign_a_q) ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                                  : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dz_d     = dz_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    sign_a_d = signed_in & bus.a[WIDTH-1];
                    sign_b_d = signed_in & bus.b[WIDTH-1];
                    dz_d     = dz_in;
                    if (is_div_in) begin
                        // Divide-by-zero keeps the raw dividend so FIX can return it in hi
                        acc_d  = {{WIDTH{1'b0}}, (dz_in ? bus.a : mag_a)};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                    if (dz_in) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = S_CALC;
                    end
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - 1'b1;
                acc_d = op_q[1] ? acc_div_next : acc_mul_next;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (dz_q) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = '1;
                end else if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dz_q     <= dz_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = done_q & dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {div_by_zero, hi, lo} queued at issue,
// popped and compared by a monitor whenever done is seen.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [2*W:0] sb_q[$];
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    // Architectural reference: plain 64-bit arithmetic, {div_by_zero, hi, lo}
    function automatic logic [2*W:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'd0: begin p = 64'(sa * sb); return {1'b0, p}; end
            2'd1: begin p = ua * ub;      return {1'b0, p}; end
            2'd2: begin
                if (b == '0) return {1'b1, a, {W{1'b1}}};
                q = 64'(sa / sb);
                r = 64'(sa % sb);
                return {1'b0, r[W-1:0], q[W-1:0]};
            end
            default: begin
                if (b == '0) return {1'b1, a, {W{1'b1}}};
                q = ua / ub;
                r = ua % ub;
                return {1'b0, r[W-1:0], q[W-1:0]};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called at posedge+#1 with the unit idle; returns at posedge+#1 in the done cycle
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit with_mthi, input bit inject);
        logic [2*W:0] e;
        int  n;
        bit  hold_ok;
        e = ref_model(op, a, b);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        bus.mthi  = with_mthi; bus.wdata = 32'hDEAD_BEEF;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0;
        hold_ok = ({bus.hi, bus.lo} === {exp_hi, exp_lo});
        n = 0;
        while (bus.busy && n < 100) begin
            if (inject && n == 5) begin
                bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
                bus.a = ~a; bus.b = 32'd3; bus.op = ~op; bus.wdata = 32'hCAFE_F00D;
            end
            @(posedge clk); #1;
            bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            n++;
            if (bus.busy && ({bus.hi, bus.lo} !== {exp_hi, exp_lo})) hold_ok = 1'b0;
        end
        check("hilo_hold", {{(2*W){1'b0}}, hold_ok}, {{(2*W){1'b0}}, 1'b1});
        check("latency", (2*W+1)'(n), (2*W+1)'(e[2*W] ? 1 : W + 1));
        check("done_at_end", {{(2*W){1'b0}}, bus.done}, {{(2*W){1'b0}}, 1'b1});
        exp_hi = e[2*W-1:W];
        exp_lo = e[W-1:0];
    endtask

    task automatic mt(input bit wh, input bit wl, input logic [W-1:0] d);
        bus.mthi = wh; bus.mtlo = wl; bus.wdata = d;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        if (wh) exp_hi = d;
        if (wl) exp_lo = d;
        check("mt_hilo", {1'b0, bus.hi, bus.lo}, {1'b0, exp_hi, exp_lo});
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;

        fork
            forever begin
                logic [2*W:0] e;
                @(negedge clk);
                if (!reset && bus.done) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done actual=done required=no_done hi=%h lo=%h",
                                 bus.hi, bus.lo);
                    end else begin
                        e = sb_q.pop_front();
                        $display("[TB] result dbz=%0d hi=%h lo=%h", bus.div_by_zero, bus.hi, bus.lo);
                        check("result", {bus.div_by_zero, bus.hi, bus.lo}, e);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus.div_by_zero, bus.hi, bus.lo}, '0);
        check("reset_busy_done", {{(2*W-1){1'b0}}, bus.busy, bus.done}, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        issue(2'd3, 32'd7, 32'd2, 1'b0, 1'b0);
        issue(2'd3, 32'd7, 32'd0, 1'b0, 1'b0);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);

        mt(1'b1, 1'b0, 32'h1234);
        mt(1'b0, 1'b1, 32'h5678);
        mt(1'b1, 1'b1, 32'hA5A5_0F0F);
        issue(2'd3, 32'd7, 32'd2, 1'b1, 1'b0);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Abort a MULT mid-CALC with reset
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd123; bus.b = 32'd456;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check("abort_hilo", {bus.div_by_zero, bus.hi, bus.lo}, '0);
        check("abort_busy_done", {{(2*W-1){1'b0}}, bus.busy, bus.done}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        issue(2'd1, 32'd2, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = (($urandom_range(0, 7)) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'd1;
                3:       rb = 32'($urandom_range(1, 255));
                default: rb = 32'($urandom);
            endcase
            if (($urandom_range(0, 5)) == 0) mt(1'($urandom), 1'($urandom), 32'($urandom));
            issue(rop, ra, rb, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", (2*W+1)'(sb_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
